ccip_c0_rd_arbiter: RTL and testbench

- Shares one CCI-P channel-0 read-request port between NUM_REQ requesters using round-robin arbitration.
- Issues requests only while the host is not asserting c0TxAlmFull. Enforces a per-requester cap on outstanding cache lines.
- Routes channel-0 read responses back to the issuing requester using requester-ID bits placed in mdata.
- Sits between AFU read engines and the host channel in the ccip afu_ifcs layer.

---
 rtl/ccip_c0_rd_arbiter.sv | 155 +++++++++++++++
 tb/tb_ccip_c0_rd_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_c0_rd_arbiter.sv
// ccip_c0_rd_arbiter: round-robin share of the CCI-P c0 read port,
// with per-requester line credits and mdata-tagged response routing.
module ccip_c0_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_BITS    = $clog2(NUM_REQ),
  parameter int MAX_LINES  = 64,
  parameter int DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*74-1:0]   req_hdr,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    c0TxAlmFull,
  output logic                    c0tx_valid,
  output logic [73:0]             c0tx_hdr,
  input  logic                    rx_rspValid,
  input  logic [27:0]             rx_hdr,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [27:0]             rsp_hdr,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [NUM_REQ*9-1:0]    outstanding
);
  localparam int HW    = 74;
  localparam int ID_LO = 16 - ID_BITS;
  localparam logic [3:0] RSP_RDLINE = 4'h0;
  localparam logic [9:0] MAX_L = 10'(MAX_LINES);

  // cl_len encoding 2'b10 is illegal and costs one line
  function automatic logic [3:0] lines_of(
    input logic [1:0] len
  );
    logic [3:0] n;
    n = 4'd1;
    unique case (1'b1)
      (len == 2'b01): n = 4'd2;
      (len == 2'b11): n = 4'd4;
      default:        n = 4'd1;
    endcase
    return n;
  endfunction

  logic [8:0] cnt_q [NUM_REQ];
  logic [8:0] cnt_d [NUM_REQ];
  logic [ID_BITS-1:0] ptr_q, ptr_d;
  logic c0tx_valid_q, c0tx_valid_d;
  logic [HW-1:0] c0tx_hdr_q, c0tx_hdr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [27:0] rsp_hdr_q, rsp_hdr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] elig, bad_len, dec;
  logic [3:0] lines [NUM_REQ];
  logic [ID_BITS-1:0] gnt_idx, sel_idx, rsp_id;
  logic found, rsp_rd;
  logic [HW-1:0] gnt_hdr;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lines[i]   = lines_of(req_hdr[i*HW+68 +: 2]);
      bad_len[i] = req_valid[i] &&
                   (req_hdr[i*HW+68 +: 2] == 2'b10);
      elig[i]    = req_valid[i] &&
                   (({1'b0, cnt_q[i]} + 10'(lines[i]))
                    <= MAX_L);
    end
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sel_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_idx = ID_BITS'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && !c0TxAlmFull && elig[sel_idx]) begin
        found   = 1'b1;
        gnt_idx = sel_idx;
      end
    end
    req_ready = '0;
    if (found) req_ready[gnt_idx] = 1'b1;
    ptr_d = ptr_q;
    if (found)
      ptr_d = (int'(gnt_idx) == NUM_REQ-1) ? '0
            : gnt_idx + ID_BITS'(1);
    gnt_hdr = req_hdr[int'(gnt_idx)*HW +: HW];
    gnt_hdr[15:ID_LO] = gnt_idx;
    c0tx_valid_d = found;
    c0tx_hdr_d   = found ? gnt_hdr : c0tx_hdr_q;
  end

  // responses for unknown ids or idle counters are stale; drop them
  always_comb begin
    rsp_id = rx_hdr[15:ID_LO];
    rsp_rd = rx_rspValid && (rx_hdr[19:16] == RSP_RDLINE);
    for (int i = 0; i < NUM_REQ; i++)
      dec[i] = rsp_rd && (rsp_id == ID_BITS'(i)) &&
               (cnt_q[i] != '0);
    rsp_valid_d = dec;
    rsp_hdr_d   = rsp_hdr_q;
    rsp_data_d  = rsp_data_q;
    if (|dec) begin
      rsp_hdr_d = rx_hdr;
      rsp_hdr_d[15:ID_LO] = '0;
      rsp_data_d = rx_data;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i] - {8'd0, dec[i]};
      if (found && gnt_idx == ID_BITS'(i))
        cnt_d[i] = cnt_d[i] + {5'd0, lines[i]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      ptr_q        <= '0;
      c0tx_valid_q <= 1'b0;
      c0tx_hdr_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_hdr_q    <= '0;
      rsp_data_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      ptr_q        <= ptr_d;
      c0tx_valid_q <= c0tx_valid_d;
      c0tx_hdr_q   <= c0tx_hdr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hdr_q    <= rsp_hdr_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign c0tx_valid = c0tx_valid_q;
  assign c0tx_hdr   = c0tx_hdr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_hdr    = rsp_hdr_q;
  assign rsp_data   = rsp_data_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      outstanding[i*9 +: 9] = cnt_q[i];
  end

  a_cl_len: assert property (
    @(posedge clk) disable iff (!reset_n)
    bad_len == '0);

  a_rsp_drop: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(rsp_rd && dec == '0))
    else $warning("c0 rsp dropped, id %0d", rsp_id);

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// tb_ccip_c0_rd_arbiter: vector table plus scoreboard queues
// for the c0 read arbiter (MAX_LINES=4 to reach the credit cap).
module tb_ccip_c0_rd_arbiter;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int ML = 4;
  localparam int NV = 45;

  logic clk = 1'b0;
  logic reset_n;
  logic [N-1:0] req_valid;
  logic [N*74-1:0] req_hdr;
  logic [N-1:0] req_ready;
  logic c0TxAlmFull;
  logic c0tx_valid;
  logic [73:0] c0tx_hdr;
  logic rx_rspValid;
  logic [27:0] rx_hdr;
  logic [DW-1:0] rx_data;
  logic [N-1:0] rsp_valid;
  logic [27:0] rsp_hdr;
  logic [DW-1:0] rsp_data;
  logic [N*9-1:0] outstanding;

  ccip_c0_rd_arbiter #(
    .NUM_REQ(N), .MAX_LINES(ML), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_hdr(req_hdr),
    .req_ready(req_ready), .c0TxAlmFull(c0TxAlmFull),
    .c0tx_valid(c0tx_valid), .c0tx_hdr(c0tx_hdr),
    .rx_rspValid(rx_rspValid), .rx_hdr(rx_hdr),
    .rx_data(rx_data), .rsp_valid(rsp_valid),
    .rsp_hdr(rsp_hdr), .rsp_data(rsp_data),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      valid;
    logic [1:0]      len;
    logic            alm;
    logic            rsp_en;
    logic [1:0]      rsp_id;
    logic            umsg;
    logic            rsp_exp;
    logic [3:0]      exp_ready;
    logic [3:0][8:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [3:0]    v;
    logic [27:0]   h;
    logic [DW-1:0] d;
  } rsp_t;

  vec_t tv [NV];
  logic [73:0] c0_q [$];
  rsp_t rq [$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [3:0] va,
                      input logic [1:0] ln, input logic al,
                      input logic ren, input logic [1:0] rid,
                      input logic um, input logic rex,
                      input logic [3:0] rdy,
                      input logic [8:0] c3, input logic [8:0] c2,
                      input logic [8:0] c1, input logic [8:0] c0);
    tv[i].valid = va;     tv[i].len = ln;
    tv[i].alm = al;       tv[i].rsp_en = ren;
    tv[i].rsp_id = rid;   tv[i].umsg = um;
    tv[i].rsp_exp = rex;  tv[i].exp_ready = rdy;
    tv[i].exp_cnt = {c3, c2, c1, c0};
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst c0tx_valid", c0tx_valid, '0);
    chk("rst c0tx_hdr", c0tx_hdr, '0);
    chk("rst rsp_valid", rsp_valid, '0);
    chk("rst rsp_hdr", rsp_hdr, '0);
    chk("rst rsp_data", rsp_data, '0);
    chk("rst outstanding", outstanding, '0);
    req_valid = '0;
    rx_rspValid = 1'b0;
    c0TxAlmFull = 1'b0;
    c0_q.delete();
    rq.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    rsp_t e;
    logic [73:0] h;
    int g;
    v = tv[vi];
    req_valid = v.valid;
    c0TxAlmFull = v.alm;
    for (int i = 0; i < N; i++)
      req_hdr[i*74 +: 74] = {4'h0, v.len, 4'h0, 6'h0,
                             42'(vi*8+i), 2'b00,
                             14'(vi*16+i)};
    rx_rspValid = v.rsp_en;
    rx_hdr = {2'b00, 1'b0, 1'b1, 2'b01, 2'(vi),
              (v.umsg ? 4'h4 : 4'h0), v.rsp_id, 14'h0005};
    rx_data = {16{$urandom}};
    #1;
    chk($sformatf("v%0d req_ready", vi), req_ready,
        v.exp_ready);
    if (v.exp_ready != '0) begin
      g = 0;
      for (int i = 0; i < N; i++)
        if (v.exp_ready[i]) g = i;
      h = req_hdr[g*74 +: 74];
      h[15:14] = 2'(g);
      c0_q.push_back(h);
    end
    if (v.rsp_exp) begin
      e.v = 4'b0001 << v.rsp_id;
      e.h = rx_hdr;
      e.h[15:14] = 2'b00;
      e.d = rx_data;
      rq.push_back(e);
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d c0tx_valid", vi), c0tx_valid,
        DW'(c0_q.size() != 0));
    if (c0_q.size() != 0) begin
      h = c0_q.pop_front();
      if (c0tx_valid)
        chk($sformatf("v%0d c0tx_hdr", vi), c0tx_hdr, h);
    end
    if (rq.size() != 0) begin
      e = rq.pop_front();
      chk($sformatf("v%0d rsp_valid", vi), rsp_valid, e.v);
      chk($sformatf("v%0d rsp_hdr", vi), rsp_hdr, e.h);
      chk($sformatf("v%0d rsp_data", vi), rsp_data, e.d);
    end else begin
      chk($sformatf("v%0d rsp_valid", vi), rsp_valid, '0);
    end
    chk($sformatf("v%0d outstanding", vi), outstanding,
        v.exp_cnt);
  endtask

  initial begin
    // fairness: 0,1,2,3 repeating until every counter hits 4
    for (int k = 0; k < 16; k++) begin
      setv(k, 4'hF, 2'b00, 0, 0, 0, 0, 0,
           4'(1 << (k % 4)), 0, 0, 0, 0);
      for (int j = 0; j < N; j++)
        tv[k].exp_cnt[j] = (k >= j) ? 9'((k - j) / 4 + 1) : 9'd0;
    end
    setv(16, 4'hF, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 4, 4, 4, 4);
    setv(17, 4'h0, 2'b00, 0, 1, 3, 0, 1, 4'b0000, 3, 4, 4, 4);
    setv(18, 4'h0, 2'b00, 0, 1, 2, 1, 0, 4'b0000, 3, 4, 4, 4);
    setv(19, 4'hF, 2'b00, 0, 0, 0, 0, 0, 4'b1000, 4, 4, 4, 4);
    // almost-full stall on cycles 5..9
    for (int k = 0; k < 12; k++) begin
      setv(20 + k, 4'b0100, 2'b00, (k >= 5 && k <= 9),
           (k >= 1 && k <= 4), 2, 0, (k >= 1 && k <= 4),
           (k >= 5 && k <= 9) ? 4'b0000 : 4'b0100,
           0, (k == 10) ? 9'd2 : (k == 11) ? 9'd3 : 9'd1,
           0, 0);
    end
    // credit cap on requester 1
    setv(32, 4'b0010, 2'b11, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 4, 0);
    setv(33, 4'b0010, 2'b11, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 4, 0);
    setv(34, 4'b0010, 2'b11, 0, 1, 1, 0, 1, 4'b0000, 0, 0, 3, 0);
    setv(35, 4'b0010, 2'b11, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 3, 0);
    setv(36, 4'b0010, 2'b00, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 4, 0);
    // same-cycle issue and response on requester 0
    setv(37, 4'b0001, 2'b01, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 2);
    setv(38, 4'b0001, 2'b01, 0, 1, 0, 0, 1, 4'b0001, 0, 0, 0, 3);
    setv(39, 4'b0001, 2'b00, 0, 1, 0, 0, 1, 4'b0001, 0, 0, 0, 3);
    setv(40, 4'b0001, 2'b00, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 4);
    // build {2,0,1,4} then reset with a request in flight
    setv(41, 4'b0001, 2'b11, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 4);
    setv(42, 4'b1010, 2'b00, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 1, 4);
    setv(43, 4'b1000, 2'b01, 0, 0, 0, 0, 0, 4'b1000, 2, 0, 1, 4);
    setv(44, 4'b0000, 2'b00, 0, 1, 3, 0, 0, 4'b0000, 0, 0, 0, 0);

    reset_n = 1'b1;
    req_valid = '0;
    req_hdr = '0;
    c0TxAlmFull = 1'b0;
    rx_rspValid = 1'b0;
    rx_hdr = '0;
    rx_data = '0;
    #1;
    do_reset();
    for (int i = 0; i <= 19; i++) run_vec(i);
    do_reset();
    for (int i = 20; i <= 31; i++) run_vec(i);
    do_reset();
    for (int i = 32; i <= 36; i++) run_vec(i);
    do_reset();
    for (int i = 37; i <= 40; i++) run_vec(i);
    do_reset();
    for (int i = 41; i <= 43; i++) run_vec(i);
    do_reset();
    run_vec(44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule
